dice_roller: RTL and testbench

//  Responder to the game FSM's roll_trigger pulse. Owns the five dice values and the player hold mask.
//  On each trigger it animates the non-held dice from a free-running LFSR, then settles them to final values 1..6.
//  It then pulses roll_done. Its dice_vals feed the score calculator, which produces current_calc_score, and the display.

---
 rtl/dice_roller_if.sv | 23 ++
 rtl/dice_roller.sv | 126 ++++++++++++
 tb/tb_dice_roller.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/dice_roller_if.sv
// Game-FSM <-> dice roller bundle: roll/turn/hold requests in, dice state and roll status out.
interface dice_roller_if #(
  parameter int NUM_DICE = 5
);
  logic                    roll_trigger;
  logic                    new_turn;
  logic                    hold_toggle;
  logic [2:0]              hold_sel;
  logic [3*NUM_DICE-1:0]   dice_vals;
  logic [NUM_DICE-1:0]     hold_mask;
  logic                    busy;
  logic                    roll_done;

  modport master (
    output roll_trigger, new_turn, hold_toggle, hold_sel,
    input  dice_vals, hold_mask, busy, roll_done
  );

  modport slave (
    input  roll_trigger, new_turn, hold_toggle, hold_sel,
    output dice_vals, hold_mask, busy, roll_done
  );
endinterface

// File: rtl/dice_roller.sv
// Dice roller: owns dice values and hold mask; shuffles non-held dice from a free-running
// Galois LFSR on each trigger, settles them to 1..6, then pulses roll_done.
module dice_roller #(
  parameter int          NUM_DICE   = 5,
  parameter int          ANIM_STEPS = 8,
  parameter int          STEP_DIV   = 4,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic     clk,
  input  logic     reset,
  dice_roller_if.slave bus
);
  localparam int DW = $clog2(STEP_DIV + 1);
  localparam int SW = $clog2(ANIM_STEPS + 1);

  typedef enum logic [1:0] {IDLE, SHUFFLE, SETTLE, DONE} state_e;

  state_e                    state_q, state_d;
  logic [15:0]               lfsr_q, lfsr_d;
  logic [NUM_DICE-1:0][2:0]  dice_q, dice_d;
  logic [NUM_DICE-1:0]       hold_q, hold_d;
  logic [NUM_DICE-1:0]       settled_q, settled_d;
  logic [NUM_DICE-1:0]       fvalid;
  logic                      rolled_q, rolled_d;
  logic [DW-1:0]             div_q, div_d;
  logic [SW-1:0]             step_q, step_d;

  // Galois form, taps 16/14/13/11; a stuck-at-zero register reloads the seed.
  always_comb begin
    if (lfsr_q == 16'h0) lfsr_d = SEED;
    else                 lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  for (genvar i = 0; i < NUM_DICE; i++) begin : g_field
    assign fvalid[i] = (lfsr_q[3*i +: 3] != 3'd0) && (lfsr_q[3*i +: 3] != 3'd7);
  end

  always_comb begin
    state_d   = state_q;
    dice_d    = dice_q;
    hold_d    = hold_q;
    settled_d = settled_q;
    rolled_d  = rolled_q;
    div_d     = div_q;
    step_d    = step_q;
    if (bus.new_turn) begin
      state_d   = IDLE;
      dice_d    = '0;
      hold_d    = '0;
      settled_d = '0;
      rolled_d  = 1'b0;
      div_d     = '0;
      step_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.roll_trigger) begin
            state_d = (&hold_q) ? DONE : SHUFFLE;
            div_d   = '0;
            step_d  = '0;
          end else if (bus.hold_toggle && rolled_q) begin
            // out-of-range selects match no die and fall through untouched
            for (int i = 0; i < NUM_DICE; i++)
              if (bus.hold_sel == 3'(i)) hold_d[i] = ~hold_q[i];
          end
        end
        SHUFFLE: begin
          if (div_q == DW'(STEP_DIV - 1)) begin
            div_d = '0;
            for (int i = 0; i < NUM_DICE; i++)
              if (!hold_q[i] && fvalid[i]) dice_d[i] = lfsr_q[3*i +: 3];
            if (step_q == SW'(ANIM_STEPS - 1)) begin
              state_d   = SETTLE;
              step_d    = '0;
              settled_d = '0;
            end else begin
              step_d = step_q + SW'(1);
            end
          end else begin
            div_d = div_q + DW'(1);
          end
        end
        SETTLE: begin
          for (int i = 0; i < NUM_DICE; i++)
            if (!hold_q[i] && !settled_q[i] && fvalid[i]) begin
              dice_d[i]    = lfsr_q[3*i +: 3];
              settled_d[i] = 1'b1;
            end
          if (&(settled_d | hold_q)) state_d = DONE;
        end
        DONE: begin
          rolled_d = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED;
      dice_q    <= '0;
      hold_q    <= '0;
      settled_q <= '0;
      rolled_q  <= 1'b0;
      div_q     <= '0;
      step_q    <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      dice_q    <= dice_d;
      hold_q    <= hold_d;
      settled_q <= settled_d;
      rolled_q  <= rolled_d;
      div_q     <= div_d;
      step_q    <= step_d;
    end
  end

  assign bus.dice_vals = dice_q;
  assign bus.hold_mask = hold_q;
  assign bus.busy      = (state_q == SHUFFLE) || (state_q == SETTLE);
  assign bus.roll_done = (state_q == DONE);
endmodule

// File: tb/tb_dice_roller.sv
// Scoreboarded bench for dice_roller: a cycle model queues expected roll results, a negedge
// monitor pops them on roll_done; directed sequences cover holds, aborts, and reset.
module tb_dice_roller;
  localparam int          ND   = 5;
  localparam int          AS   = 8;
  localparam int          SD   = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dice_roller_if #(.NUM_DICE(ND)) bus();
  dice_roller #(.NUM_DICE(ND), .ANIM_STEPS(AS), .STEP_DIV(SD), .SEED(SEED))
    dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct { logic [14:0] dice; int cyc; } exp_t;
  exp_t exp_q[$];

  int  n_chk = 0, n_fail = 0, cyc = 0;
  bit  chk_en = 0;

  // reference model: 0 idle, 1 shuffle, 2 settle, 3 done
  int          m_st = 0, m_k = 0;
  logic [15:0] m_l;
  logic [2:0]  m_d [ND];
  logic [4:0]  m_hold = '0, m_set = '0;
  bit          m_rolled = 0;

  function automatic logic [15:0] nxt(logic [15:0] l);
    if (l == 16'h0) return SEED;
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [14:0] m_pack();
    logic [14:0] p;
    for (int i = 0; i < ND; i++) p[3*i +: 3] = m_d[i];
    return p;
  endfunction

  function automatic bit fok(logic [2:0] f);
    return f != 3'd0 && f != 3'd7;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  always @(posedge clk) begin
    logic [15:0] l;
    l = m_l;
    cyc++;
    if (reset) begin
      m_l = SEED; m_st = 0; m_k = 0; m_hold = '0; m_set = '0; m_rolled = 0;
      for (int i = 0; i < ND; i++) m_d[i] = 3'd0;
    end else begin
      m_l = nxt(l);
      if (bus.new_turn) begin
        m_st = 0; m_k = 0; m_hold = '0; m_set = '0; m_rolled = 0;
        for (int i = 0; i < ND; i++) m_d[i] = 3'd0;
      end else begin
        case (m_st)
          0: if (bus.roll_trigger) begin
               if (m_hold == 5'h1F) begin m_st = 3; exp_q.push_back('{m_pack(), cyc}); end
               else begin m_st = 1; m_k = 0; end
             end else if (bus.hold_toggle && m_rolled && bus.hold_sel < 3'd5)
               m_hold[bus.hold_sel] = ~m_hold[bus.hold_sel];
          1: begin
               if (m_k % SD == SD - 1)
                 for (int i = 0; i < ND; i++)
                   if (!m_hold[i] && fok(l[3*i +: 3])) m_d[i] = l[3*i +: 3];
               m_k++;
               if (m_k == AS * SD) begin m_st = 2; m_set = '0; end
             end
          2: begin
               for (int i = 0; i < ND; i++)
                 if (!m_hold[i] && !m_set[i] && fok(l[3*i +: 3])) begin
                   m_d[i] = l[3*i +: 3]; m_set[i] = 1'b1;
                 end
               if ((m_set | m_hold) == 5'h1F) begin m_st = 3; exp_q.push_back('{m_pack(), cyc}); end
             end
          default: begin m_rolled = 1; m_st = 0; end
        endcase
      end
    end
  end

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      check("busy", 32'(bus.busy), 32'(m_st == 1 || m_st == 2));
      check("hold_mask", 32'(bus.hold_mask), 32'(m_hold));
      check("dice_vals", 32'(bus.dice_vals), 32'(m_pack()));
      if (bus.roll_done) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL roll_done @cyc %0d: got unexpected pulse, expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          check("done_dice", 32'(bus.dice_vals), 32'(e.dice));
          check("done_cycle", 32'(cyc), 32'(e.cyc));
          for (int i = 0; i < ND; i++)
            check("die_range_ok", 32'(fok(bus.dice_vals[3*i +: 3])), 32'd1);
        end
      end
    end
  end

  task automatic trig(output int t0);
    @(negedge clk); bus.roll_trigger = 1'b1; t0 = cyc;
    @(negedge clk); bus.roll_trigger = 1'b0;
  endtask

  task automatic tog(input logic [2:0] sel);
    @(negedge clk); bus.hold_toggle = 1'b1; bus.hold_sel = sel;
    @(negedge clk); bus.hold_toggle = 1'b0;
  endtask

  task automatic newturn();
    @(negedge clk); bus.new_turn = 1'b1;
    @(negedge clk); bus.new_turn = 1'b0;
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      if (bus.roll_done) begin at = cyc; break; end
      @(negedge clk);
    end
    n_chk++;
    if (at < 0) begin n_fail++; $display("FAIL wait_done: got no roll_done in 200 cycles, expected one"); end
  endtask

  initial begin
    int t0, at;
    logic [2:0] d0, d2;
    logic [14:0] dv;
    reset = 1'b1;
    bus.roll_trigger = 1'b0; bus.new_turn = 1'b0; bus.hold_toggle = 1'b0; bus.hold_sel = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_dice", 32'(bus.dice_vals), 32'd0);
    check("rst_mask", 32'(bus.hold_mask), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.roll_done), 32'd0);
    check("rst_lfsr", 32'(dut.lfsr_q), 32'hACE1);
    chk_en = 1; reset = 1'b0;

    // 1: plain roll latency
    trig(t0);
    check("busy_T1", 32'(bus.busy), 32'd1);
    wait_done(at);
    check("latency_ge34", 32'(at - t0 >= 34), 32'd1);

    // 2: hold dice 0 and 2 across a roll
    tog(3'd0); tog(3'd2);
    check("mask_00101", 32'(bus.hold_mask), 32'h05);
    d0 = m_d[0]; d2 = m_d[2];
    trig(t0); wait_done(at);
    check("held_die0", 32'(bus.dice_vals[2:0]), 32'(d0));
    check("held_die2", 32'(bus.dice_vals[8:6]), 32'(d2));

    // 3: hold gating
    newturn();
    check("nt_dice", 32'(bus.dice_vals), 32'd0);
    check("nt_mask", 32'(bus.hold_mask), 32'd0);
    tog(3'd1);
    check("tog_before_roll", 32'(bus.hold_mask), 32'd0);
    trig(t0); wait_done(at);
    tog(3'd5);
    check("tog_sel5", 32'(bus.hold_mask), 32'd0);
    tog(3'd1);
    check("tog1_once", 32'(bus.hold_mask), 32'h02);
    tog(3'd1);
    check("tog1_twice", 32'(bus.hold_mask), 32'd0);
    @(negedge clk); bus.roll_trigger = 1'b1; bus.hold_toggle = 1'b1; bus.hold_sel = 3'd3;
    @(negedge clk); bus.roll_trigger = 1'b0; bus.hold_toggle = 1'b0;
    check("trig_beats_tog", 32'(bus.hold_mask), 32'd0);
    wait_done(at);

    // 4: all held
    for (int i = 0; i < ND; i++) tog(3'(i));
    check("mask_all", 32'(bus.hold_mask), 32'h1F);
    dv = bus.dice_vals;
    check("dice_nonblank", 32'(dv != 15'd0), 32'd1);
    trig(t0);
    check("allheld_busy", 32'(bus.busy), 32'd0);
    check("allheld_done", 32'(bus.roll_done), 32'd1);
    check("allheld_T1", 32'(cyc - t0), 32'd1);
    check("allheld_dice", 32'(bus.dice_vals), 32'(dv));

    // 5: abort and ignored re-trigger
    newturn();
    trig(t0);
    repeat (4) @(negedge clk);
    trig(at);
    repeat (3) @(negedge clk);
    newturn();
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_dice", 32'(bus.dice_vals), 32'd0);
    check("abort_mask", 32'(bus.hold_mask), 32'd0);
    repeat (60) @(negedge clk);
    trig(t0);
    repeat (10) @(negedge clk);
    trig(at);
    wait_done(at);
    repeat (50) @(negedge clk);

    // 6: many rolls, then reset mid-SETTLE
    for (int r = 0; r < 250; r++) begin
      if (r % 3 == 1) tog(3'(r % 5));
      trig(t0); wait_done(at);
    end
    newturn();
    trig(t0);
    repeat (32) @(negedge clk);
    check("settle_busy", 32'(bus.busy), 32'd1);
    check("settle_nodone", 32'(bus.roll_done), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_dice", 32'(bus.dice_vals), 32'd0);
    check("midrst_mask", 32'(bus.hold_mask), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.roll_done), 32'd0);
    check("midrst_lfsr", 32'(dut.lfsr_q), 32'hACE1);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
